// File: rtl/seq_detect_if.sv
// Bus between the control plane / serial source and seq_detect_ctrl.
// The master drives config, run control and serial data; the slave returns status.
interface seq_detect_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             start;
    logic             stop;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop, x, x_valid,
        input  busy, match, match_count, count_sat, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, start, stop, x, x_valid,
        output busy, match, match_count, count_sat, cfg_err
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: IDLE/RUN controller, runtime pattern
// config, overlap/non-overlap matching and a saturating match counter.
module seq_detect_ctrl #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_detect_if.slave  io
);
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(5'b11101);
    localparam logic [LEN_W-1:0] RST_LEN = LEN_W'((PAT_W < 5) ? PAT_W : 5);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_busy;
    logic             r_match;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic             r_cfg_err;

    logic [PAT_W-1:0] w_window;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_fill_inc;
    logic [LEN_W-1:0] w_fill_next;
    logic             w_len_ok;
    logic             w_hit;

    // Newest bit sits at bit 0, so pattern bit [len-1] lines up with the oldest bit.
    generate
        if (PAT_W == 1) begin : g_win1
            assign w_window = io.x;
        end else begin : g_winn
            assign w_window = {r_hist[PAT_W-2:0], io.x};
        end
    endgenerate

    assign w_mask      = ~({PAT_W{1'b1}} << r_len);
    assign w_fill_inc  = {1'b0, r_fill} + (LEN_W+1)'(1);
    assign w_fill_next = (w_fill_inc > {1'b0, r_len}) ? r_len : w_fill_inc[LEN_W-1:0];
    assign w_len_ok    = (io.cfg_len != '0) && (32'(io.cfg_len) <= 32'(PAT_W));
    assign w_hit       = (w_fill_inc >= {1'b0, r_len}) &&
                         ((w_window & w_mask) == (r_pattern & w_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pattern <= RST_PAT;
            r_len     <= RST_LEN;
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_busy    <= 1'b0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io.cfg_we) begin
                        if (w_len_ok) begin
                            r_pattern <= io.cfg_pattern;
                            r_len     <= io.cfg_len;
                            r_overlap <= io.cfg_overlap;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    if (io.start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                        r_sat   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (io.cfg_we)
                        r_cfg_err <= 1'b1;
                    if (io.stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (io.x_valid) begin
                        r_hist <= w_window;
                        if (w_hit) begin
                            r_match <= 1'b1;
                            if (&r_count)
                                r_sat <= 1'b1;
                            else
                                r_count <= r_count + CNT_W'(1);
                            // Non-overlap forces a full fresh pattern before the next hit.
                            r_fill <= r_overlap ? r_len : '0;
                        end else begin
                            r_fill <= w_fill_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io.busy        = r_busy;
    assign io.match       = r_match;
    assign io.match_count = r_count;
    assign io.count_sat   = r_sat;
    assign io.cfg_err     = r_cfg_err;
endmodule
